// File: rtl/phy_port_supervisor.sv
// Per-port Ethernet PHY supervisor: staggered power-on resets, soft re-reset, settle gating, link/activity LEDs.
// Define PHY_SUPERVISOR_ACT_BLINK_EN to blink the activity LEDs instead of lighting them solid.
module phy_port_supervisor #(
    parameter int NUM_PORTS          = 4,
    parameter int RESET_CYCLES       = 500000,
    parameter int STAGGER_CYCLES     = 125000,
    parameter int SETTLE_CYCLES      = 1000,
    parameter int ACT_STRETCH_CYCLES = 6250000,
    parameter int BLINK_HALF_CYCLES  = 3125000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] phy_rst_req,
    input  logic [NUM_PORTS-1:0] link_up,
    input  logic [NUM_PORTS-1:0] activity,
    output logic [NUM_PORTS-1:0] phy_rst_n,
    output logic [NUM_PORTS-1:0] phy_ready,
    output logic [NUM_PORTS-1:0] led_link,
    output logic [NUM_PORTS-1:0] led_act
);

    localparam int HOLD_MAX = RESET_CYCLES + (NUM_PORTS - 1) * STAGGER_CYCLES;
    localparam int CNT_MAX  = (HOLD_MAX > SETTLE_CYCLES) ? HOLD_MAX : SETTLE_CYCLES;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int ACT_W    = $clog2(ACT_STRETCH_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] RESET_LOAD  = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [ACT_W-1:0] ACT_ONE     = ACT_W'(1);
    localparam logic [ACT_W-1:0] ACT_LOAD    = ACT_W'(ACT_STRETCH_CYCLES);

    if (NUM_PORTS < 1 || NUM_PORTS > 16) begin : g_bad_num_ports
        $error("phy_port_supervisor: NUM_PORTS must be 1..16");
    end
    if (RESET_CYCLES < 1 || SETTLE_CYCLES < 1 || ACT_STRETCH_CYCLES < 1 || BLINK_HALF_CYCLES < 1) begin : g_bad_cycles
        $error("phy_port_supervisor: cycle parameters must be at least 1");
    end

    typedef enum logic [1:0] {
        HOLD,
        SETTLE,
        READY
    } port_state_t;

    logic blink_phase_next;

`ifdef PHY_SUPERVISOR_ACT_BLINK_EN
    localparam int BLINK_W = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic               blink_wrap;

    assign blink_wrap       = (blink_cnt == BLINK_LAST);
    assign blink_phase_next = blink_wrap ? ~blink_phase : blink_phase;

    // One phase shared by every port so all activity LEDs blink in unison.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else begin
            blink_cnt   <= blink_wrap ? '0 : blink_cnt + BLINK_ONE;
            blink_phase <= blink_phase_next;
        end
    end
`else
    assign blink_phase_next = 1'b1;
`endif

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        localparam logic [CNT_W-1:0] POR_LOAD = CNT_W'(RESET_CYCLES + i * STAGGER_CYCLES);

        port_state_t      state;
        logic [CNT_W-1:0] cnt;
        logic [ACT_W-1:0] stretch;
        logic [ACT_W-1:0] stretch_next;
        logic             rst_n_q;
        logic             ready_q;
        logic             link_q;
        logic             act_q;

        // The LED is registered from the next stretch value so activity shows one edge later.
        always_comb begin
            stretch_next = stretch;
            if (phy_rst_req[i]) begin
                stretch_next = '0;
            end else if (state == READY && activity[i]) begin
                stretch_next = ACT_LOAD;
            end else if (stretch != '0) begin
                stretch_next = stretch - ACT_ONE;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state   <= HOLD;
                cnt     <= POR_LOAD;
                stretch <= '0;
                rst_n_q <= 1'b0;
                ready_q <= 1'b0;
                link_q  <= 1'b0;
                act_q   <= 1'b0;
            end else begin
                stretch <= stretch_next;
                link_q  <= link_up[i] & ready_q;
                act_q   <= (stretch_next != '0) & blink_phase_next;
                if (phy_rst_req[i]) begin
                    state   <= HOLD;
                    cnt     <= RESET_LOAD;
                    rst_n_q <= 1'b0;
                    ready_q <= 1'b0;
                end else begin
                    case (state)
                        HOLD: begin
                            if (cnt == CNT_ONE) begin
                                state   <= SETTLE;
                                cnt     <= SETTLE_LOAD;
                                rst_n_q <= 1'b1;
                            end else begin
                                cnt <= cnt - CNT_ONE;
                            end
                        end
                        SETTLE: begin
                            if (cnt == CNT_ONE) begin
                                state   <= READY;
                                ready_q <= 1'b1;
                            end else begin
                                cnt <= cnt - CNT_ONE;
                            end
                        end
                        READY: begin
                            state <= READY;
                        end
                        default: begin
                            state   <= HOLD;
                            cnt     <= RESET_LOAD;
                            rst_n_q <= 1'b0;
                            ready_q <= 1'b0;
                        end
                    endcase
                end
            end
        end

        assign phy_rst_n[i] = rst_n_q;
        assign phy_ready[i] = ready_q;
        assign led_link[i]  = link_q;
        assign led_act[i]   = act_q;
    end

endmodule

// File: tb/tb_phy_port_supervisor.sv
// Directed bench for phy_port_supervisor with a queue of expected output bundles.
// Works with PHY_SUPERVISOR_ACT_BLINK_EN either defined or undefined.
module tb_phy_port_supervisor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] phy_rst_req = 2'b00;
    logic [1:0] link_up = 2'b00;
    logic [1:0] activity = 2'b00;
    logic [1:0] phy_rst_n;
    logic [1:0] phy_ready;
    logic [1:0] led_link;
    logic [1:0] led_act;

    int total = 0;
    int bad = 0;
    int k = 0;

    typedef struct {
        string      tag;
        logic [7:0] value;
    } exp_t;

    exp_t sb[$];

    phy_port_supervisor #(
        .NUM_PORTS(2),
        .RESET_CYCLES(10),
        .STAGGER_CYCLES(5),
        .SETTLE_CYCLES(4),
        .ACT_STRETCH_CYCLES(8),
        .BLINK_HALF_CYCLES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .phy_rst_req(phy_rst_req),
        .link_up(link_up),
        .activity(activity),
        .phy_rst_n(phy_rst_n),
        .phy_ready(phy_ready),
        .led_link(led_link),
        .led_act(led_act)
    );

    always #5 clk = ~clk;

    // Blink phase after a given number of edges since reset release (solid when blinking is off).
    function automatic logic phase(input int edges);
`ifdef PHY_SUPERVISOR_ACT_BLINK_EN
        return ((edges / 3) % 2) == 0;
`else
        return edges >= 0;
`endif
    endfunction

    task automatic applyStimulus(input string tag, input logic [1:0] rn, input logic [1:0] rd,
                                 input logic [1:0] ll, input logic [1:0] la);
        exp_t e;
        e.tag   = tag;
        e.value = {rn, rd, ll, la};
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t       e;
        logic [7:0] observed;
        observed = {phy_rst_n, phy_ready, led_link, led_act};
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("[TB] FAIL scoreboard_empty observed=%b expected=<entry>", observed);
        end else begin
            e = sb.pop_front();
            assert (observed === e.value)
            else begin
                bad++;
                $error("[TB] FAIL %s k=%0d observed rn/rd/ll/la=%b expected=%b", e.tag, k, observed, e.value);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic step(input string tag, input logic [1:0] rn, input logic [1:0] rd,
                        input logic [1:0] ll, input logic [1:0] la);
        applyStimulus(tag, rn, rd, ll, la);
        tick();
        checkOutput();
    endtask

    // Staggered power-on with link up throughout and an ignored activity pulse while in HOLD.
    task automatic powerOnSequence(input string tag);
        for (int j = 1; j <= 20; j++) begin
            activity = (j == 3) ? 2'b01 : 2'b00;
            step(tag, {j >= 15, j >= 10}, {j >= 19, j >= 14}, {j >= 20, j >= 15}, 2'b00);
        end
        activity = 2'b00;
    endtask

    initial begin
        #12;
        applyStimulus("reset_state", 2'b00, 2'b00, 2'b00, 2'b00);
        checkOutput();

        link_up = 2'b11;
        rst     = 1'b0;
        k       = 0;
        powerOnSequence("power_on");

        activity = 2'b01;
        for (int j = 0; j < 11; j++) begin
            step("act_single", 2'b11, 2'b11, 2'b11, {1'b0, (j < 8) & phase(k + 1)});
            activity = 2'b00;
        end

        for (int j = 0; j < 16; j++) begin
            activity = (j == 0 || j == 5) ? 2'b01 : 2'b00;
            step("act_extend", 2'b11, 2'b11, 2'b11, {1'b0, (j < 13) & phase(k + 1)});
        end
        activity = 2'b00;

        activity = 2'b01;
        for (int j = 0; j < 12; j++) begin
            step("act_held", 2'b11, 2'b11, 2'b11, {1'b0, phase(k + 1)});
        end
        activity = 2'b00;
        for (int j = 0; j < 9; j++) begin
            step("act_tail", 2'b11, 2'b11, 2'b11, {1'b0, (j < 7) & phase(k + 1)});
        end

        for (int j = 0; j <= 16; j++) begin
            phy_rst_req = (j == 0) ? 2'b10 : 2'b00;
            step("soft_rst_p1", {j >= 10, 1'b1}, {j >= 14, 1'b1}, {(j == 0) || (j >= 15), 1'b1}, 2'b00);
        end
        phy_rst_req = 2'b00;

        for (int j = 0; j <= 21; j++) begin
            phy_rst_req = (j <= 5) ? 2'b01 : 2'b00;
            activity    = (j == 8) ? 2'b01 : 2'b00;
            step("held_rst_p0", {1'b1, j >= 15}, {1'b1, j >= 19}, {1'b1, (j == 0) || (j >= 20)}, 2'b00);
        end
        phy_rst_req = 2'b00;
        activity    = 2'b00;

        activity = 2'b10;
        step("act_p1_pre_rst", 2'b11, 2'b11, 2'b11, {phase(k + 1), 1'b0});
        activity = 2'b00;
        step("act_p1_pre_rst", 2'b11, 2'b11, 2'b11, {phase(k + 1), 1'b0});

        #2;
        rst = 1'b1;
        #1;
        applyStimulus("async_rst", 2'b00, 2'b00, 2'b00, 2'b00);
        checkOutput();
        step("rst_held", 2'b00, 2'b00, 2'b00, 2'b00);

        rst = 1'b0;
        k   = 0;
        powerOnSequence("power_on_again");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
